lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Initiator-side load/store controller that sits between the RV32I core's memory stage and the single-port system RAM.
- Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide RAM accesses.
- Performs sign/zero extension on loads and read-modify-write merging for sub-word stores.
- Detects misaligned and illegal accesses and reports them without touching RAM.

Parameters:
- MEM_AW, 10, RAM word-address width. RAM is 2^MEM_AW 32-bit words. Byte address bits [MEM_AW+1:2] select the word; bits above MEM_AW+1 are ignored (aliasing).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents an access request
- req_ready  out  1  controller accepts request this cycle (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned or illegal access
- mem_we  out  1  RAM write enable
- mem_addr  out  MEM_AW  RAM word address
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, valid the cycle after mem_addr is sampled (registered read address)

Behaviour:
- States: IDLE, CAP, MERGE, WR, RESP.
- Accept: a request is accepted when req_valid && req_ready. On accept, latch we, funct3, addr[MEM_AW+1:0], and wdata.
- req_ready is 1 only when state is IDLE and rst_n is high. Requests while busy are ignored; the core holds req_* stable until it is accepted.
- mem_addr is req_addr[MEM_AW+1:2] in IDLE and the latched word address in every other state. The accept cycle therefore always issues a RAM read, which is harmless for word stores.
- Error check at accept:
  - illegal: funct3 ∈ {011, 110, 111}, or a store with funct3 ∈ {100, 101}
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0
  - On error: go to RESP with err=1 and issue no mem_we.
- Transitions:
  - IDLE → CAP for a load, → WR for SW, → MERGE for SB/SH, → RESP on error.
  - CAP: capture mem_dout, select byte/half by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU, W), register into resp_rdata → RESP.
  - MERGE: merged = mem_dout with the addressed byte lane (SB) or half lane (SH, addr[1]) replaced by wdata[7:0] or [15:0]; register into the write-data reg → WR.
  - WR: mem_we=1 for exactly this cycle; mem_din = write-data reg (SW: latched wdata unmodified) → RESP.
  - RESP: resp_valid=1 for one cycle with resp_rdata and resp_err stable → IDLE.
- Latency, counted from the accept edge T0; resp_valid is high in cycle:
  - load: T2
  - SW: T2
  - SB/SH: T3
  - error: T1
- Next accept is possible in the cycle after RESP, so back-to-back word loads are 3 cycles each.
- mem_we is decoded from the state register (state==WR) only, never combinationally from req_*.
- mem_din is 0 outside WR.
- resp_rdata and resp_err hold their values until the next RESP; the core samples them only when resp_valid is high.
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, latched regs=0. req_ready=0 while rst_n is low.
- Reset mid-operation: asserting rst_n low drops mem_we and resp_valid immediately. A pending WR is abandoned and RAM is unmodified; a pending load produces no response.
- Sub-word store to the same word as an immediately preceding store reads the updated data, because RAM read follows write (new data visible after the edge).

Test Plan:
- SW addr=0x3FC, wdata=0x0000002A, then LW addr=0x3FC → mem_we pulse at T1 with mem_addr=255 and mem_din=0x2A; LW resp_valid at T2 with rdata=0x0000002A, err=0.
- RAM word 4 = 0x80FF7F01: LB 0x10 → 0x00000001; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80FF; LHU 0x12 → 0x000080FF.
- RAM word 4 = 0x11223344: SB 0x11 wdata=0xAB → word becomes 0x1122AB44; then SH 0x12 wdata=0xBEEF → 0xBEEFAB44. resp_valid at T3 for each; exactly one mem_we pulse each.
- LW 0x102, SH 0x101, and funct3=011 → resp_valid at T1 with err=1 and rdata=0; mem_we never asserted; RAM unchanged.
- req_valid held high with a second request during CAP/RESP → req_ready=0 and the second request is not accepted until the IDLE cycle after resp_valid; both responses are correct and in order.
- Assert rst_n low during the WR cycle of an SW to 0x3FC (old value 5) → mem_we falls immediately, no resp_valid, LW 0x3FC after reset returns 5.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
// into word accesses on a single-port RAM with a registered read address.
module lsu_mem_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_MERGE,
    S_WR,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [MEM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merged;
  logic              w_unused;

  // Address bits above the RAM window alias onto it.
  assign w_unused = &{1'b0, req_addr[31:MEM_AW+2]};

  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

  // Request classification, evaluated on the incoming request at accept.
  always_comb begin
    w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    w_err      = w_illegal || w_misalign;
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                    w_next = S_RESP;
          else if (!req_we)             w_next = S_CAP;
          else if (req_funct3 == F3_W)  w_next = S_WR;
          else                          w_next = S_MERGE;
        end
      end
      S_CAP:   w_next = S_RESP;
      S_MERGE: w_next = S_WR;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Lane extraction for loads; r_addr[1:0] picks the byte, r_addr[1] the half.
  always_comb begin
    w_byte = mem_dout[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_dout[7:0];
      2'd1: w_byte = mem_dout[15:8];
      2'd2: w_byte = mem_dout[23:16];
      2'd3: w_byte = mem_dout[31:24];
      default: w_byte = mem_dout[7:0];
    endcase
    w_half = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];

    w_load_data = mem_dout;
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load_data = {24'd0, w_byte};
      F3_HU:   w_load_data = {16'd0, w_half};
      default: w_load_data = mem_dout;
    endcase
  end

  // Read-modify-write: replace only the addressed lane of the current word.
  always_comb begin
    w_merged = mem_dout;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = mem_dout;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  // Response registers only change on the transition into RESP, so they
  // hold steady between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[MEM_AW+1:0];
            r_wdata  <= req_wdata;
            if (w_err) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end
          end
        end
        S_CAP: begin
          r_rdata <= w_load_data;
          r_err   <= 1'b0;
        end
        S_MERGE: r_wdata <= w_merged;
        S_WR: begin
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM strobes come straight from registered state, never from req_*.
  assign mem_we     = (r_state == S_WR) && r_we;
  assign mem_din    = mem_we ? r_wdata : 32'd0;
  assign mem_addr   = (r_state == S_IDLE) ? req_addr[MEM_AW+1:2] : r_addr[MEM_AW+1:2];
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
